// File: rtl/branch_unit_if.sv
// Decoder-facing bundle of the branch unit: phase strobes, transfer requests,
// condition select, flags and target in; program counter and stack status out.
interface branch_unit_if #(
  parameter int PC_WIDTH   = 8,
  parameter int FLAG_COUNT = 4
);
  localparam int SEL_WIDTH = (FLAG_COUNT > 1) ? $clog2(FLAG_COUNT) : 1;

  logic                  increment;
  logic                  execute;
  logic                  jump;
  logic                  call;
  logic                  ret;
  logic                  cond_always;
  logic [SEL_WIDTH-1:0]  cond_sel;
  logic                  cond_invert;
  logic [FLAG_COUNT-1:0] flags;
  logic [PC_WIDTH-1:0]   target;
  logic [PC_WIDTH-1:0]   pc;
  logic                  taken;
  logic                  stack_full;
  logic                  stack_empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output increment, execute, jump, call, ret,
    output cond_always, cond_sel, cond_invert, flags, target,
    input  pc, taken, stack_full, stack_empty, overflow, underflow
  );

  modport slave (
    input  increment, execute, jump, call, ret,
    input  cond_always, cond_sel, cond_invert, flags, target,
    output pc, taken, stack_full, stack_empty, overflow, underflow
  );
endinterface

// File: rtl/branch_unit.sv
// Program counter sequencer: increments, jumps, calls and returns through an
// internal return-address stack with sticky overflow/underflow flags.
module branch_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int FLAG_COUNT  = 4,
  parameter int STACK_DEPTH = 4
) (
  input logic          clock,
  input logic          clear,
  branch_unit_if.slave bus
);
  localparam int SEL_WIDTH = (FLAG_COUNT > 1) ? $clog2(FLAG_COUNT) : 1;
  localparam int FLAG_EXT  = 1 << SEL_WIDTH;
  localparam int SP_WIDTH  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_WIDTH = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [SP_WIDTH-1:0] sp_q;
  logic [SP_WIDTH-1:0] sp_dec;
  logic                taken_q;
  logic                suppress_q;
  logic                overflow_q;
  logic                underflow_q;

  logic [FLAG_EXT-1:0] flags_ext;
  logic [FLAG_EXT-1:0] valid_ext;
  logic                cond;
  logic                full;
  logic                empty;
  logic                want_ret;
  logic                want_call;
  logic                want_jump;
  logic                do_ret;
  logic                do_call;
  logic                transfer;

  // Selects past the last real flag land on a zero valid bit, so they can never satisfy a condition.
  assign flags_ext = FLAG_EXT'(bus.flags);
  assign valid_ext = FLAG_EXT'({FLAG_COUNT{1'b1}});
  assign cond      = bus.cond_always |
                     (valid_ext[bus.cond_sel] & (flags_ext[bus.cond_sel] ^ bus.cond_invert));

  assign full   = (sp_q == SP_WIDTH'(STACK_DEPTH));
  assign empty  = (sp_q == '0);
  assign sp_dec = sp_q - SP_WIDTH'(1);

  assign want_ret  = bus.execute & bus.ret & cond;
  assign want_call = bus.execute & bus.call & ~bus.ret & cond;
  assign want_jump = bus.execute & bus.jump & ~bus.call & ~bus.ret & cond;
  assign do_ret    = want_ret & ~empty;
  assign do_call   = want_call & ~full;
  assign transfer  = do_ret | do_call | want_jump;

  always_ff @(posedge clock) begin
    if (do_call && !clear) begin
      stack_mem[sp_q[IDX_WIDTH-1:0]] <= pc_q;
    end
  end

  // A performed transfer wins over a fetch strobe and arms suppress so the target itself is fetched first.
  always_ff @(posedge clock) begin
    if (clear) begin
      pc_q        <= '0;
      sp_q        <= '0;
      taken_q     <= 1'b0;
      suppress_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      taken_q <= transfer;
      if (transfer) begin
        suppress_q <= 1'b1;
        pc_q       <= do_ret ? stack_mem[sp_dec[IDX_WIDTH-1:0]] : bus.target;
        if (do_call) begin
          sp_q <= sp_q + SP_WIDTH'(1);
        end
        if (do_ret) begin
          sp_q <= sp_dec;
        end
      end else if (bus.increment) begin
        if (suppress_q) begin
          suppress_q <= 1'b0;
        end else begin
          pc_q <= pc_q + PC_WIDTH'(1);
        end
      end
      if (want_call && full) begin
        overflow_q <= 1'b1;
      end
      if (want_ret && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.pc          = pc_q;
  assign bus.taken       = taken_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: every step pushes the reference model's
// expected outputs to a scoreboard, which is popped and compared after the edge.
module tb_branch_unit;
  localparam int PC_WIDTH    = 8;
  localparam int FLAG_COUNT  = 4;
  localparam int STACK_DEPTH = 4;

  typedef struct packed {
    logic [7:0] pc;
    logic       taken;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
  } expect_t;

  logic clock = 1'b0;
  logic clear;

  branch_unit_if #(.PC_WIDTH(PC_WIDTH), .FLAG_COUNT(FLAG_COUNT)) bus ();

  branch_unit #(
    .PC_WIDTH   (PC_WIDTH),
    .FLAG_COUNT (FLAG_COUNT),
    .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  expect_t    scoreboard[$];
  int         assert_count = 0;
  int         fail_count   = 0;
  logic [7:0] m_pc;
  logic [7:0] m_stack[$];
  logic       m_taken;
  logic       m_sup;
  logic       m_ovf;
  logic       m_unf;

  function automatic expect_t model_snapshot();
    expect_t e;
    e.pc    = m_pc;
    e.taken = m_taken;
    e.full  = (m_stack.size() == STACK_DEPTH);
    e.empty = (m_stack.size() == 0);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  task automatic check_field(input string tag, input logic [7:0] got, input logic [7:0] exp_v);
    assert_count++;
    assert (got === exp_v)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp_v);
    end
  endtask

  task automatic checkOutput();
    expect_t exp_v;
    exp_v = scoreboard.pop_front();
    check_field("pc",          bus.pc,                 exp_v.pc);
    check_field("taken",       {7'd0, bus.taken},       {7'd0, exp_v.taken});
    check_field("stack_full",  {7'd0, bus.stack_full},  {7'd0, exp_v.full});
    check_field("stack_empty", {7'd0, bus.stack_empty}, {7'd0, exp_v.empty});
    check_field("overflow",    {7'd0, bus.overflow},    {7'd0, exp_v.ovf});
    check_field("underflow",   {7'd0, bus.underflow},   {7'd0, exp_v.unf});
  endtask

  task automatic applyStimulus(input logic inc, input logic exe, input logic j, input logic c,
                               input logic r, input logic alw, input logic [1:0] sel,
                               input logic inv, input logic [3:0] flg, input logic [7:0] tgt);
    logic cond;
    logic xfer;
    clear           = 1'b0;
    bus.increment   = inc;
    bus.execute     = exe;
    bus.jump        = j;
    bus.call        = c;
    bus.ret         = r;
    bus.cond_always = alw;
    bus.cond_sel    = sel;
    bus.cond_invert = inv;
    bus.flags       = flg;
    bus.target      = tgt;
    cond = alw | (flg[sel] ^ inv);
    xfer = 1'b0;
    if (exe && r) begin
      if (cond) begin
        if (m_stack.size() == 0) m_unf = 1'b1;
        else begin
          m_pc = m_stack.pop_back();
          xfer = 1'b1;
        end
      end
    end else if (exe && c) begin
      if (cond) begin
        if (m_stack.size() == STACK_DEPTH) m_ovf = 1'b1;
        else begin
          m_stack.push_back(m_pc);
          m_pc = tgt;
          xfer = 1'b1;
        end
      end
    end else if (exe && j && cond) begin
      m_pc = tgt;
      xfer = 1'b1;
    end
    if (xfer) begin
      m_taken = 1'b1;
      m_sup   = 1'b1;
    end else begin
      m_taken = 1'b0;
      if (inc) begin
        if (m_sup) m_sup = 1'b0;
        else m_pc = m_pc + 8'd1;
      end
    end
    scoreboard.push_back(model_snapshot());
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  task automatic apply_reset(input logic exe, input logic c);
    clear           = 1'b1;
    bus.increment   = 1'b1;
    bus.execute     = exe;
    bus.jump        = 1'b0;
    bus.call        = c;
    bus.ret         = 1'b0;
    bus.cond_always = 1'b1;
    bus.cond_sel    = 2'd0;
    bus.cond_invert = 1'b0;
    bus.flags       = 4'd0;
    bus.target      = 8'h99;
    m_pc = 8'd0;
    m_stack.delete();
    m_taken = 1'b0;
    m_sup   = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    scoreboard.push_back(model_snapshot());
    @(posedge clock);
    #1;
    checkOutput();
    clear = 1'b0;
  endtask

  task automatic step_inc();
    applyStimulus(1, 0, 0, 0, 0, 0, 2'd0, 0, 4'd0, 8'd0);
  endtask

  task automatic step_jump_always(input logic [7:0] tgt);
    applyStimulus(0, 1, 1, 0, 0, 1, 2'd0, 0, 4'd0, tgt);
  endtask

  task automatic step_call_always(input logic [7:0] tgt);
    applyStimulus(0, 1, 0, 1, 0, 1, 2'd0, 0, 4'd0, tgt);
  endtask

  task automatic step_ret_always();
    applyStimulus(0, 1, 0, 0, 1, 1, 2'd0, 0, 4'd0, 8'd0);
  endtask

  initial begin
    apply_reset(0, 0);

    repeat (3) step_inc();
    check_field("plan_pc_after_incs", bus.pc, 8'd3);

    applyStimulus(0, 1, 1, 0, 0, 0, 2'd0, 0, 4'b0001, 8'h40);
    check_field("plan_jump_taken", {7'd0, bus.taken}, 8'd1);
    step_inc();
    check_field("plan_fetch_target", bus.pc, 8'h40);
    step_inc();
    check_field("plan_fetch_next", bus.pc, 8'h41);

    applyStimulus(0, 1, 1, 0, 0, 0, 2'd1, 1, 4'b0010, 8'h50);
    check_field("plan_inverted_not_taken", bus.pc, 8'h41);
    applyStimulus(0, 1, 1, 0, 0, 0, 2'd1, 1, 4'b0000, 8'h50);
    check_field("plan_inverted_taken", bus.pc, 8'h50);
    step_inc();
    applyStimulus(1, 1, 1, 0, 0, 0, 2'd2, 0, 4'b1011, 8'h60);
    check_field("plan_refused_with_inc", bus.pc, 8'h51);

    step_jump_always(8'h10);
    step_call_always(8'h20);
    check_field("plan_call_target", bus.pc, 8'h20);
    step_ret_always();
    check_field("plan_ret_addr", bus.pc, 8'h10);

    for (int i = 1; i <= 5; i++) begin
      step_jump_always(8'(i));
      step_call_always(8'(8'h10 + i));
    end
    check_field("plan_overflow", {7'd0, bus.overflow}, 8'd1);
    check_field("plan_overflow_pc", bus.pc, 8'd5);
    for (int i = 4; i >= 1; i--) begin
      step_ret_always();
      check_field("plan_nested_ret", bus.pc, 8'(i));
    end
    step_ret_always();
    check_field("plan_underflow", {7'd0, bus.underflow}, 8'd1);

    step_jump_always(8'hFF);
    step_inc();
    step_inc();
    check_field("plan_wrap", bus.pc, 8'h00);

    applyStimulus(1, 1, 1, 0, 0, 1, 2'd0, 0, 4'd0, 8'h77);
    check_field("plan_inc_with_jump", bus.pc, 8'h77);

    apply_reset(1, 1);

    applyStimulus(0, 1, 1, 1, 0, 1, 2'd0, 0, 4'd0, 8'h30);
    check_field("plan_call_over_jump", bus.pc, 8'h30);
    applyStimulus(0, 1, 1, 1, 1, 1, 2'd0, 0, 4'd0, 8'h99);
    check_field("plan_ret_over_all", bus.pc, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule
